// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline register: control bundle layout,
// ALU operation encodings and the NOP bundle.
package id_ex_pkg;

    localparam int CTRLBITS = 21;

    localparam int CTRL_REG_WRITE   = 20;
    localparam int CTRL_ALU_SOURCE  = 19;
    localparam int CTRL_MEM_WRITE   = 18;
    localparam int CTRL_ALU_OP_HI   = 17;
    localparam int CTRL_ALU_OP_LO   = 15;
    localparam int CTRL_MEM_TO_REG  = 14;
    localparam int CTRL_MEM_READ    = 13;
    localparam int CTRL_BEQ         = 12;
    localparam int CTRL_BNE         = 11;
    localparam int CTRL_JUMP        = 10;
    localparam int CTRL_REG_DST_HI  = 9;
    localparam int CTRL_REG_DST_LO  = 8;
    localparam int CTRL_SEL_ADDR_HI = 7;
    localparam int CTRL_SEL_ADDR_LO = 6;
    localparam int CTRL_SIZE_HI     = 5;
    localparam int CTRL_SIZE_LO     = 1;
    localparam int CTRL_LINK        = 0;

    typedef enum logic [2:0] {
        ALU_RTYPE  = 3'b000,
        ALU_ADDI   = 3'b001,
        ALU_ANDI   = 3'b010,
        ALU_ORI    = 3'b011,
        ALU_XORI   = 3'b100,
        ALU_SLTI   = 3'b101,
        ALU_LUI    = 3'b110,
        ALU_BRANCH = 3'b111
    } alu_op_e;

    // All-zero bundle: no writes, no branches, Select_Addr 00 is inert here.
    localparam logic [CTRLBITS-1:0] NOP_CTRL = '0;

    function automatic logic isMemRead(input logic [CTRLBITS-1:0] ctrl);
        return ctrl[CTRL_MEM_READ];
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX whose destination is
// read by the instruction in ID.
module load_use_detect #(
    parameter int RBITS = 5
) (
    input  logic             i_ex_valid,
    input  logic             i_ex_mem_read,
    input  logic [RBITS-1:0] i_ex_rt,
    input  logic [RBITS-1:0] i_id_rs,
    input  logic [RBITS-1:0] i_id_rt,
    output logic             o_hazard
);

    // Both ID indices are compared regardless of instruction format.
    always_comb begin
        o_hazard = i_ex_valid & i_ex_mem_read & (i_ex_rt != '0) &
                   ((i_ex_rt == i_id_rs) | (i_ex_rt == i_id_rt));
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use stall/bubble, flush, debug freeze and
// a saturating bubble counter.
module id_ex_reg #(
    parameter int NBITS    = 32,
    parameter int RBITS    = 5,
    parameter int CTRLBITS = id_ex_pkg::CTRLBITS,
    parameter int CNTBITS  = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_flush,
    input  logic [CTRLBITS-1:0] i_ctrl,
    input  logic [NBITS-1:0]    i_pc_next,
    input  logic [NBITS-1:0]    i_rs_data,
    input  logic [NBITS-1:0]    i_rt_data,
    input  logic [NBITS-1:0]    i_imm,
    input  logic [RBITS-1:0]    i_rs,
    input  logic [RBITS-1:0]    i_rt,
    input  logic [RBITS-1:0]    i_rd,
    input  logic [4:0]          i_shamt,
    input  logic [5:0]          i_funct,
    output logic [CTRLBITS-1:0] o_ctrl,
    output logic [NBITS-1:0]    o_pc_next,
    output logic [NBITS-1:0]    o_rs_data,
    output logic [NBITS-1:0]    o_rt_data,
    output logic [NBITS-1:0]    o_imm,
    output logic [RBITS-1:0]    o_rs,
    output logic [RBITS-1:0]    o_rt,
    output logic [RBITS-1:0]    o_rd,
    output logic [4:0]          o_shamt,
    output logic [5:0]          o_funct,
    output logic                o_valid,
    output logic                o_stall,
    output logic [CNTBITS-1:0]  o_bubble_count
);
    import id_ex_pkg::*;

    logic [CTRLBITS-1:0] ctrl_q, ctrl_d;
    logic [NBITS-1:0]    pcNext_q, pcNext_d;
    logic [NBITS-1:0]    rsData_q, rsData_d;
    logic [NBITS-1:0]    rtData_q, rtData_d;
    logic [NBITS-1:0]    imm_q, imm_d;
    logic [RBITS-1:0]    rs_q, rs_d;
    logic [RBITS-1:0]    rt_q, rt_d;
    logic [RBITS-1:0]    rd_q, rd_d;
    logic [4:0]          shamt_q, shamt_d;
    logic [5:0]          funct_q, funct_d;
    logic                valid_q, valid_d;
    logic [CNTBITS-1:0]  count_q, count_d;
    logic                hazard;

    load_use_detect #(.RBITS(RBITS)) u_detect (
        .i_ex_valid    (valid_q),
        .i_ex_mem_read (ctrl_q[CTRL_MEM_READ]),
        .i_ex_rt       (rt_q),
        .i_id_rs       (i_rs),
        .i_id_rt       (i_rt),
        .o_hazard      (hazard)
    );

    assign o_stall = hazard & i_enable & ~i_flush;

    // Flush outranks hazard, so a squashed instruction never costs a bubble.
    always_comb begin
        ctrl_d   = ctrl_q;
        pcNext_d = pcNext_q;
        rsData_d = rsData_q;
        rtData_d = rtData_q;
        imm_d    = imm_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        shamt_d  = shamt_q;
        funct_d  = funct_q;
        valid_d  = valid_q;
        count_d  = count_q;
        if (i_enable) begin
            pcNext_d = i_pc_next;
            rsData_d = i_rs_data;
            rtData_d = i_rt_data;
            imm_d    = i_imm;
            rs_d     = i_rs;
            rt_d     = i_rt;
            rd_d     = i_rd;
            shamt_d  = i_shamt;
            funct_d  = i_funct;
            if (i_flush) begin
                ctrl_d  = CTRLBITS'(NOP_CTRL);
                valid_d = 1'b0;
            end else if (hazard) begin
                ctrl_d  = CTRLBITS'(NOP_CTRL);
                valid_d = 1'b0;
                if (!(&count_q))
                    count_d = count_q + CNTBITS'(1);
            end else begin
                ctrl_d  = i_ctrl;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ctrl_q   <= '0;
            pcNext_q <= '0;
            rsData_q <= '0;
            rtData_q <= '0;
            imm_q    <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            shamt_q  <= '0;
            funct_q  <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            pcNext_q <= pcNext_d;
            rsData_q <= rsData_d;
            rtData_q <= rtData_d;
            imm_q    <= imm_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            shamt_q  <= shamt_d;
            funct_q  <= funct_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign o_ctrl         = ctrl_q;
    assign o_pc_next      = pcNext_q;
    assign o_rs_data      = rsData_q;
    assign o_rt_data      = rtData_q;
    assign o_imm          = imm_q;
    assign o_rs           = rs_q;
    assign o_rt           = rt_q;
    assign o_rd           = rd_q;
    assign o_shamt        = shamt_q;
    assign o_funct        = funct_q;
    assign o_valid        = valid_q;
    assign o_bubble_count = count_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized self-checking bench for id_ex_reg against a behavioural model
// of the EX-stage contents and bubble count.
module tb_id_ex_reg;
    import id_ex_pkg::*;

    localparam int NB   = 32;
    localparam int RB   = 5;
    localparam int CNTW = 3;
    localparam int CNTMAX = (1 << CNTW) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic                flush;
    logic [CTRLBITS-1:0] ctrl;
    logic [NB-1:0]       pcNext, rsData, rtData, imm;
    logic [RB-1:0]       rs, rt, rd;
    logic [4:0]          shamt;
    logic [5:0]          funct;

    logic [CTRLBITS-1:0] oCtrl;
    logic [NB-1:0]       oPcNext, oRsData, oRtData, oImm;
    logic [RB-1:0]       oRs, oRt, oRd;
    logic [4:0]          oShamt;
    logic [5:0]          oFunct;
    logic                oValid, oStall;
    logic [CNTW-1:0]     oBubbleCount;

    // Model of what EX should be holding.
    logic [CTRLBITS-1:0] mCtrl;
    logic [NB-1:0]       mPc, mRsD, mRtD, mImm;
    logic [RB-1:0]       mRs, mRt, mRd;
    logic [4:0]          mShamt;
    logic [5:0]          mFunct;
    logic                mValid;
    int                  mCount;

    int checks = 0;
    int errors = 0;

    localparam logic [CTRLBITS-1:0] ADDI_CTRL = 21'h188000;
    localparam logic [CTRLBITS-1:0] LW_CTRL   = 21'h18A000;
    localparam logic [CTRLBITS-1:0] RTYPE_CTRL = 21'h100200;

    always #5 clk = ~clk;

    id_ex_reg #(.NBITS(NB), .RBITS(RB), .CTRLBITS(CTRLBITS), .CNTBITS(CNTW)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_flush(flush),
        .i_ctrl(ctrl), .i_pc_next(pcNext), .i_rs_data(rsData), .i_rt_data(rtData),
        .i_imm(imm), .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_shamt(shamt), .i_funct(funct),
        .o_ctrl(oCtrl), .o_pc_next(oPcNext), .o_rs_data(oRsData), .o_rt_data(oRtData),
        .o_imm(oImm), .o_rs(oRs), .o_rt(oRt), .o_rd(oRd), .o_shamt(oShamt),
        .o_funct(oFunct), .o_valid(oValid), .o_stall(oStall),
        .o_bubble_count(oBubbleCount)
    );

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic logic modelHazard();
        return mValid && mCtrl[CTRL_MEM_READ] && (mRt != 0) && (mRt == rs || mRt == rt);
    endfunction

    task automatic modelReset();
        mCtrl = '0; mPc = '0; mRsD = '0; mRtD = '0; mImm = '0;
        mRs = '0; mRt = '0; mRd = '0; mShamt = '0; mFunct = '0;
        mValid = 1'b0; mCount = 0;
    endtask

    // Apply one clock edge to the model using the inputs as currently driven.
    task automatic modelEdge();
        logic hz;
        hz = modelHazard();
        if (!enable) return;
        mPc = pcNext; mRsD = rsData; mRtD = rtData; mImm = imm;
        mRs = rs; mRt = rt; mRd = rd; mShamt = shamt; mFunct = funct;
        if (flush) begin
            mCtrl = '0; mValid = 1'b0;
        end else if (hz) begin
            mCtrl = '0; mValid = 1'b0;
            if (mCount < CNTMAX) mCount = mCount + 1;
        end else begin
            mCtrl = ctrl; mValid = 1'b1;
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "/ctrl"}, 128'(oCtrl), 128'(mCtrl));
        checkOutput({tag, "/valid"}, 128'(oValid), 128'(mValid));
        checkOutput({tag, "/count"}, 128'(oBubbleCount), 128'(mCount));
        checkOutput({tag, "/data"}, {oPcNext, oRsData, oRtData, oImm}, {mPc, mRsD, mRtD, mImm});
        checkOutput({tag, "/fields"}, 128'({oRs, oRt, oRd, oShamt, oFunct}),
                    128'({mRs, mRt, mRd, mShamt, mFunct}));
    endtask

    task automatic applyStimulus(input logic en, input logic fl, input logic [CTRLBITS-1:0] c,
                                 input logic [RB-1:0] s, input logic [RB-1:0] t);
        enable = en; flush = fl; ctrl = c; rs = s; rt = t;
        rd = RB'($urandom); shamt = 5'($urandom); funct = 6'($urandom);
        pcNext = $urandom; rsData = $urandom; rtData = $urandom; imm = $urandom;
    endtask

    task automatic randomStimulus();
        logic [CTRLBITS-1:0] c;
        c = CTRLBITS'($urandom);
        c[CTRL_MEM_READ] = ($urandom_range(0, 1) == 1);
        applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0, c,
                      RB'($urandom_range(0, 3)), RB'($urandom_range(0, 3)));
    endtask

    // Inputs are already driven just after a falling edge.
    task automatic runCycle(input string tag);
        #1;
        checkOutput({tag, "/stall"}, 128'(oStall), 128'(modelHazard() & enable & ~flush));
        @(posedge clk);
        modelEdge();
        #1;
        checkAll(tag);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, '0, '0, '0);
        modelReset();
        #12;
        checkAll("reset");
        checkOutput("reset/stall", 128'(oStall), 128'(0));
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(1'b1, 1'b0, ADDI_CTRL, 5'd3, 5'd4);
        runCycle("addi");
        checkOutput("addi_ctrl", 128'(oCtrl), 128'(21'h188000));
        checkOutput("addi_rs", 128'(oRs), 128'(3));
        checkOutput("addi_valid", 128'(oValid), 128'(1));

        applyStimulus(1'b1, 1'b0, LW_CTRL, 5'd1, 5'd5);
        runCycle("lw");
        applyStimulus(1'b1, 1'b0, RTYPE_CTRL, 5'd5, 5'd2);
        #1;
        checkOutput("lu_stall_now", 128'(oStall), 128'(1));
        runCycle("lu_bubble");
        checkOutput("lu_valid", 128'(oValid), 128'(0));
        checkOutput("lu_count", 128'(oBubbleCount), 128'(1));
        #1;
        checkOutput("lu_stall_after", 128'(oStall), 128'(0));
        runCycle("lu_resume");

        applyStimulus(1'b1, 1'b0, LW_CTRL, 5'd2, 5'd0);
        runCycle("lw_r0");
        applyStimulus(1'b1, 1'b0, RTYPE_CTRL, 5'd0, 5'd0);
        runCycle("zero_reg");
        checkOutput("zero_count", 128'(oBubbleCount), 128'(1));

        applyStimulus(1'b1, 1'b0, LW_CTRL, 5'd2, 5'd6);
        runCycle("lw_r6");
        applyStimulus(1'b1, 1'b1, RTYPE_CTRL, 5'd6, 5'd1);
        #1;
        checkOutput("flush_stall", 128'(oStall), 128'(0));
        runCycle("flush_hz");
        checkOutput("flush_valid", 128'(oValid), 128'(0));
        checkOutput("flush_count", 128'(oBubbleCount), 128'(1));

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, LW_CTRL, RB'(i + 7), RB'(i + 8));
            runCycle("freeze");
        end
        applyStimulus(1'b1, 1'b0, ADDI_CTRL, 5'd9, 5'd10);
        runCycle("unfreeze");

        for (int i = 0; i < 300; i++) begin
            randomStimulus();
            runCycle("random");
        end

        applyStimulus(1'b1, 1'b0, LW_CTRL, 5'd1, 5'd7);
        runCycle("lw_r7");
        applyStimulus(1'b1, 1'b0, RTYPE_CTRL, 5'd7, 5'd7);
        #1;
        checkOutput("midreset_stall_before", 128'(oStall), 128'(1));
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        checkAll("midreset");
        checkOutput("midreset_stall", 128'(oStall), 128'(0));
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, LW_CTRL, 5'd5, 5'd5);
            runCycle("sat");
        end
        checkOutput("sat_count", 128'(oBubbleCount), 128'(CNTMAX));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
ID/EX pipeline register for the 5-stage MIPS core. It captures the packed control bundle produced by the decode controller, together with the decoded operands, and presents them to the EX stage. It owns load-use hazard detection: on a hazard it stalls PC and IF/ID and injects a bubble into EX. It also handles branch/jump flush and debug-unit step enable, and keeps a saturating bubble counter for the debug unit.

Parameters:
NBITS, 32, datapath/PC width
RBITS, 5, register index width
CTRLBITS, 21, packed control bundle width (layout fixed in package)
CNTBITS, 16, bubble counter width

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  debug-unit run/step enable; 0 = freeze register
i_flush  in  1  squash the ID instruction (taken branch/jump resolved)
i_ctrl  in  CTRLBITS  packed control bundle from the decode controller
i_pc_next  in  NBITS  PC+4 of the ID instruction
i_rs_data  in  NBITS  register file read port A
i_rt_data  in  NBITS  register file read port B
i_imm  in  NBITS  sign-extended immediate
i_rs / i_rt / i_rd  in  RBITS each  register indices of the ID instruction
i_shamt  in  5  shift amount
i_funct  in  6  funct field
o_ctrl  out  CTRLBITS  registered control bundle to EX
o_pc_next, o_rs_data, o_rt_data, o_imm  out  NBITS each  registered operands
o_rs, o_rt, o_rd  out  RBITS each  registered indices (forwarding unit uses o_rs/o_rt)
o_shamt  out  5;  o_funct  out  6  registered fields
o_valid  out  1  EX holds a real instruction (not a bubble)
o_stall  out  1  combinational; hold PC and IF/ID this cycle
o_bubble_count  out  CNTBITS  number of load-use bubbles inserted, saturating

Behaviour:
- Single clock i_clk; reset i_reset is asynchronous, active-high.
- Reset: every registered output is 0, including o_valid and o_bubble_count.
- hazard (comb) = o_valid & o_ctrl[MEM_READ] & (o_rt != 0) & ((o_rt == i_rs) | (o_rt == i_rt)). This is a conservative comparison on both indices, whatever the ID instruction's format.
- o_stall = hazard & i_enable & ~i_flush.
- Per rising edge, first matching case applies:
  1. i_enable = 0: hold all registers, including the counter.
  2. i_flush = 1: o_ctrl <= 0, o_valid <= 0; data/index fields capture inputs; counter unchanged.
  3. hazard = 1: bubble. o_ctrl <= 0, o_valid <= 0; data fields capture inputs; counter += 1 and saturates at all-ones.
  4. otherwise: all fields capture inputs, o_valid <= 1.
- Latency: exactly 1 cycle from ID inputs to EX outputs.
- A bubble clears Mem_read in EX, so a load-use stall lasts exactly one cycle. Back-to-back dependent loads each stall once.
- A zero control bundle is a legal NOP: Select_Addr = 00 is harmless because Jump/BEQ/BNE are 0.
- If flush and hazard occur together, flush wins: no stall, no counter increment.
- Reset asserted mid-stall clears the register immediately. o_stall then drops combinationally because o_valid = 0.

Decomposition:
- Package id_ex_pkg holds the CTRLBITS localparam and the bundle bit positions: [20] Reg_write, [19] ALU_source, [18] Mem_write, [17:15] ALU_op, [14] Mem_to_Reg, [13] MEM_READ, [12] BEQ, [11] BNE, [10] Jump, [9:8] Reg_dst, [7:6] Select_Addr, [5:1] Size_control, [0] Link.
- The ALU_op encodings and the NOP bundle constant also go in the package.
- Sub-module load_use_detect (combinational) computes hazard from the EX index/control and the ID indices.

Test Plan:
- Reset: assert i_reset between edges -> all outputs 0 immediately. Release, drive Addi ctrl (Reg_write=1, ALU_source=1, ALU_op=001) with i_rs=3 -> next edge o_valid=1 and o_ctrl=0x180200... wait, no: o_ctrl equals the driven bundle with bits [20], [19] and [15] set, and o_rs=3.
- Load-use: EX holds Lw with o_rt=5; ID i_rs=5 -> o_stall=1 that cycle; next edge o_valid=0, o_ctrl=0, o_bubble_count=1; following cycle o_stall=0.
- Zero register: EX Lw with o_rt=0, ID i_rs=0 -> o_stall=0, no bubble, counter stays 0.
- Flush vs hazard: load-use condition plus i_flush=1 -> o_stall=0, next o_valid=0, counter unchanged.
- Freeze: i_enable=0 for 3 edges with changing inputs -> outputs constant and o_stall=0; i_enable=1 -> capture resumes.
- Saturation: preload the counter by forcing 65535 hazards, or use CNTBITS=2 with 4 hazards -> count stops at 3.
